jpeg_rle: RTL and testbench
===========================

Name: jpeg_rle

Overview:
- Entropy-prep stage directly downstream of the DCT/quantizer accelerator.
- After a quantized 8x8 block has been written to the output block RAM, this block reads the block in zigzag order through a second read port.
- It forms the DC difference against a running predictor and run-length codes the AC coefficients.
- It emits one (run, size, amplitude) symbol per handshake to the Huffman packer.

Parameters:
- ADDR_W, 5, output-memory word address width (32 words x 2 coefficients).
- COEF_W, 16, stored coefficient width (two's complement).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  pulse; begin scanning the block held in output memory.
- clr_dc_i  in  1  pulse; zero the DC predictor (restart interval or new component).
- busy_o  out  1  high from accepted start until done.
- done_o  out  1  one-cycle pulse after the last symbol is accepted.
- mem_addr_o  out  ADDR_W  output-memory read address.
- mem_dat_i  in  32  read data, valid exactly one cycle after the address.
- sym_valid_o  out  1  symbol valid.
- sym_ready_i  in  1  consumer ready.
- sym_dc_o  out  1  symbol is the DC difference.
- sym_run_o  out  4  zero run (AC only; 0 for DC and EOB, 15 for ZRL).
- sym_size_o  out  4  magnitude category, 0..11.
- sym_amp_o  out  11  amplitude bits, LSB-aligned, zero above size.

Behaviour:
- Reset values: every output is 0. DC predictor is 0 and the FSM is in IDLE.
- Memory layout:
  - Natural-order coefficient n (row-major, 0..63) is in word n>>1.
  - Bits 31:16 hold even n; bits 15:0 hold odd n.
- Zigzag mapping: an internal 64-entry ROM maps scan index k to the standard JPEG zigzag natural index.
- Saturation: each coefficient read is saturated to [-1023,1023] before use.
- Size and amplitude:
  - size = bit length of |v|, with size(0) = 0.
  - amp = v if v > 0; otherwise (v-1) truncated to size bits.
- FSM states: IDLE, RD, CHK, EMIT, ZRL, EOB, FIN.
- IDLE:
  - On start_i: busy_o goes high next cycle, k=0, run=0, go to RD.
  - If clr_dc_i arrives in the same cycle as start_i, the predictor is cleared first.
  - clr_dc_i outside IDLE is ignored.
  - start_i while busy is ignored.
- RD: drive mem_addr_o = zz(k)>>1, then go to CHK. Data is sampled in CHK.
- CHK, k=0 (DC):
  - diff = v - pred, computed in 13 bits and saturated to [-2047,2047].
  - pred <= pred + saturated diff.
  - Load the DC symbol (dc=1, run=0) and go to EMIT.
- CHK, k>0 with v=0:
  - run++.
  - If k=63, go to EOB; else k++ and go to RD.
- CHK, k>0 with v≠0:
  - If run ≥ 16, go to ZRL.
  - Otherwise load the symbol (run, size, amp) and go to EMIT.
- ZRL:
  - Present run=15, size=0, amp=0, dc=0.
  - On handshake, run -= 16.
  - Remain in ZRL while run ≥ 16; otherwise load the pending symbol and go to EMIT.
  - ZRLs are emitted only ahead of a nonzero coefficient; trailing zeros never produce ZRL.
- EMIT:
  - sym_valid_o high.
  - On sym_valid_o && sym_ready_i: run=0; if k=63 go to FIN, else k++ and go to RD.
- EOB:
  - Present run=0, size=0, amp=0, dc=0.
  - On handshake, go to FIN.
  - EOB is produced only when the coefficient at k=63 is zero.
- FIN: pulse done_o, drop busy_o, return to IDLE.
- Symbol hold: while valid and not ready, every sym_* output is held stable. valid never drops without a handshake.
- Reset: rst_i at any time aborts the scan and restores reset values, including predictor 0. No symbol or done_o pulse follows.
- Throughput: 2 cycles per zero coefficient; symbols are 1 cycle each when ready is held high.
- Latency example: an all-zero-AC block with ready held high takes 2 + 1 + 63×2 + 1 + 1 cycles from start to done.

Test Plan:
- Pred 0, block DC=5, all AC 0, ready=1 -> DC symbol (size 3, amp 101b), then EOB, then done_o. Exactly 2 symbols.
- Same block again without clr_dc_i -> DC size 0, amp 0, then EOB. Then clr_dc_i with DC=-3 -> size 2, amp 00b.
- DC=0, only natural index 1 (k=1) = -1 -> DC size0; run0/size1/amp0; EOB.
- Only k=20 nonzero (=1) -> DC, ZRL (run15), run3/size1/amp1, EOB.
- Only k=63 nonzero (=1023) -> DC, 3×ZRL, run14/size10/amp 3FFh. No EOB.
- Coefficient 3000 saturates to 1023 -> size 10.
- Hold sym_ready_i low 10 cycles during an AC symbol -> outputs stable, no address advance; the scan resumes on ready.
- rst_i asserted mid-scan (k≈30) -> next cycle busy_o=0, sym_valid_o=0. The next block's DC diff uses pred=0.

Source files
------------

// File: rtl/jpeg_rle.sv
// Entropy-prep stage: scans a quantized 8x8 block in zigzag order, forms the DC
// difference against a running predictor and run-length codes the AC terms.
module jpeg_rle #(
  parameter int ADDR_W = 5,
  parameter int COEF_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              clr_dc_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       mem_dat_i,
  output logic              sym_valid_o,
  input  logic              sym_ready_i,
  output logic              sym_dc_o,
  output logic [3:0]        sym_run_o,
  output logic [3:0]        sym_size_o,
  output logic [10:0]       sym_amp_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_RD = 3'd1, S_CHK = 3'd2, S_EMIT = 3'd3,
    S_ZRL  = 3'd4, S_EOB = 3'd5, S_FIN = 3'd6
  } state_t;

  localparam logic signed [COEF_W-1:0] COEF_MAX = COEF_W'(1023);
  localparam logic signed [COEF_W-1:0] COEF_MIN = -COEF_MAX;

  function automatic logic [5:0] zz_map(input logic [5:0] k);
    case (k)
      6'd0:  zz_map = 6'd0;  6'd1:  zz_map = 6'd1;  6'd2:  zz_map = 6'd8;  6'd3:  zz_map = 6'd16;
      6'd4:  zz_map = 6'd9;  6'd5:  zz_map = 6'd2;  6'd6:  zz_map = 6'd3;  6'd7:  zz_map = 6'd10;
      6'd8:  zz_map = 6'd17; 6'd9:  zz_map = 6'd24; 6'd10: zz_map = 6'd32; 6'd11: zz_map = 6'd25;
      6'd12: zz_map = 6'd18; 6'd13: zz_map = 6'd11; 6'd14: zz_map = 6'd4;  6'd15: zz_map = 6'd5;
      6'd16: zz_map = 6'd12; 6'd17: zz_map = 6'd19; 6'd18: zz_map = 6'd26; 6'd19: zz_map = 6'd33;
      6'd20: zz_map = 6'd40; 6'd21: zz_map = 6'd48; 6'd22: zz_map = 6'd41; 6'd23: zz_map = 6'd34;
      6'd24: zz_map = 6'd27; 6'd25: zz_map = 6'd20; 6'd26: zz_map = 6'd13; 6'd27: zz_map = 6'd6;
      6'd28: zz_map = 6'd7;  6'd29: zz_map = 6'd14; 6'd30: zz_map = 6'd21; 6'd31: zz_map = 6'd28;
      6'd32: zz_map = 6'd35; 6'd33: zz_map = 6'd42; 6'd34: zz_map = 6'd49; 6'd35: zz_map = 6'd56;
      6'd36: zz_map = 6'd57; 6'd37: zz_map = 6'd50; 6'd38: zz_map = 6'd43; 6'd39: zz_map = 6'd36;
      6'd40: zz_map = 6'd29; 6'd41: zz_map = 6'd22; 6'd42: zz_map = 6'd15; 6'd43: zz_map = 6'd23;
      6'd44: zz_map = 6'd30; 6'd45: zz_map = 6'd37; 6'd46: zz_map = 6'd44; 6'd47: zz_map = 6'd51;
      6'd48: zz_map = 6'd58; 6'd49: zz_map = 6'd59; 6'd50: zz_map = 6'd52; 6'd51: zz_map = 6'd45;
      6'd52: zz_map = 6'd38; 6'd53: zz_map = 6'd31; 6'd54: zz_map = 6'd39; 6'd55: zz_map = 6'd46;
      6'd56: zz_map = 6'd53; 6'd57: zz_map = 6'd60; 6'd58: zz_map = 6'd61; 6'd59: zz_map = 6'd54;
      6'd60: zz_map = 6'd47; 6'd61: zz_map = 6'd55; 6'd62: zz_map = 6'd62; 6'd63: zz_map = 6'd63;
      default: zz_map = 6'd0;
    endcase
  endfunction

  function automatic logic signed [11:0] sat_coef(input logic signed [COEF_W-1:0] c);
    if (c > COEF_MAX) begin
      sat_coef = 12'sd1023;
    end else if (c < COEF_MIN) begin
      sat_coef = -12'sd1023;
    end else begin
      sat_coef = c[11:0];
    end
  endfunction

  function automatic logic [3:0] bit_size(input logic signed [11:0] v);
    logic [11:0] mag;
    mag = v[11] ? 12'(-v) : 12'(v);
    bit_size = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (mag[i]) begin
        bit_size = 4'(i + 1);
      end else begin
        bit_size = bit_size;
      end
    end
  endfunction

  // Negative values carry (v-1), i.e. the one's complement of |v|, in size bits.
  function automatic logic [10:0] amp_bits(input logic signed [11:0] v, input logic [3:0] sz);
    logic [11:0] t;
    logic [10:0] mask;
    if (v[11]) begin
      t = 12'(v - 12'sd1);
    end else begin
      t = 12'(v);
    end
    mask = 11'((12'd1 << sz) - 12'd1);
    amp_bits = t[10:0] & mask;
  endfunction

  state_t              state_r, state_nxt_s;
  logic [5:0]          k_r, k_nxt_s;
  logic [5:0]          run_r, run_nxt_s;
  logic signed [11:0]  pred_r, pred_nxt_s;
  logic                pend_dc_r, pend_dc_nxt_s;
  logic [3:0]          pend_run_r, pend_run_nxt_s;
  logic [3:0]          pend_size_r, pend_size_nxt_s;
  logic [10:0]         pend_amp_r, pend_amp_nxt_s;

  logic [5:0]          zz_s;
  logic signed [COEF_W-1:0] coef_raw_s;
  logic signed [11:0]  coef_s;
  logic signed [12:0]  dc_raw_s;
  logic signed [11:0]  dc_diff_s;
  logic [5:0]          run_dec_s;
  logic                hs_s;

  logic                busy_nxt_s, done_nxt_s, valid_nxt_s, dc_nxt_s;
  logic [ADDR_W-1:0]   addr_nxt_s;
  logic [3:0]          run_out_nxt_s, size_nxt_s;
  logic [10:0]         amp_nxt_s;

  // Coefficient selection, saturation and DC difference for the current scan index.
  always_comb begin
    zz_s       = zz_map(k_r);
    coef_raw_s = zz_s[0] ? mem_dat_i[COEF_W-1:0] : mem_dat_i[16+COEF_W-1:16];
    coef_s     = sat_coef(coef_raw_s);
    dc_raw_s   = {coef_s[11], coef_s} - {pred_r[11], pred_r};
    if (dc_raw_s > 13'sd2047) begin
      dc_diff_s = 12'sd2047;
    end else if (dc_raw_s < -13'sd2047) begin
      dc_diff_s = -12'sd2047;
    end else begin
      dc_diff_s = dc_raw_s[11:0];
    end
    run_dec_s = run_r - 6'd16;
    hs_s      = sym_valid_o & sym_ready_i;
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= S_IDLE;
      k_r         <= 6'd0;
      run_r       <= 6'd0;
      pred_r      <= 12'sd0;
      pend_dc_r   <= 1'b0;
      pend_run_r  <= 4'd0;
      pend_size_r <= 4'd0;
      pend_amp_r  <= 11'd0;
    end else begin
      state_r     <= state_nxt_s;
      k_r         <= k_nxt_s;
      run_r       <= run_nxt_s;
      pred_r      <= pred_nxt_s;
      pend_dc_r   <= pend_dc_nxt_s;
      pend_run_r  <= pend_run_nxt_s;
      pend_size_r <= pend_size_nxt_s;
      pend_amp_r  <= pend_amp_nxt_s;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_nxt_s     = state_r;
    k_nxt_s         = k_r;
    run_nxt_s       = run_r;
    pred_nxt_s      = pred_r;
    pend_dc_nxt_s   = pend_dc_r;
    pend_run_nxt_s  = pend_run_r;
    pend_size_nxt_s = pend_size_r;
    pend_amp_nxt_s  = pend_amp_r;
    case (state_r)
      S_IDLE: begin
        if (clr_dc_i) begin
          pred_nxt_s = 12'sd0;
        end else begin
          pred_nxt_s = pred_r;
        end
        if (start_i) begin
          state_nxt_s = S_RD;
          k_nxt_s     = 6'd0;
          run_nxt_s   = 6'd0;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RD: state_nxt_s = S_CHK;
      S_CHK: begin
        if (k_r == 6'd0) begin
          pred_nxt_s      = pred_r + dc_diff_s;
          pend_dc_nxt_s   = 1'b1;
          pend_run_nxt_s  = 4'd0;
          pend_size_nxt_s = bit_size(dc_diff_s);
          pend_amp_nxt_s  = amp_bits(dc_diff_s, bit_size(dc_diff_s));
          state_nxt_s     = S_EMIT;
        end else if (coef_s == 12'sd0) begin
          run_nxt_s = run_r + 6'd1;
          if (k_r == 6'd63) begin
            state_nxt_s = S_EOB;
          end else begin
            k_nxt_s     = k_r + 6'd1;
            state_nxt_s = S_RD;
          end
        end else begin
          pend_dc_nxt_s   = 1'b0;
          pend_size_nxt_s = bit_size(coef_s);
          pend_amp_nxt_s  = amp_bits(coef_s, bit_size(coef_s));
          if (run_r >= 6'd16) begin
            state_nxt_s = S_ZRL;
          end else begin
            pend_run_nxt_s = run_r[3:0];
            state_nxt_s    = S_EMIT;
          end
        end
      end
      S_ZRL: begin
        if (hs_s) begin
          run_nxt_s = run_dec_s;
          if (run_dec_s >= 6'd16) begin
            state_nxt_s = S_ZRL;
          end else begin
            pend_run_nxt_s = run_dec_s[3:0];
            state_nxt_s    = S_EMIT;
          end
        end else begin
          state_nxt_s = S_ZRL;
        end
      end
      S_EMIT: begin
        if (hs_s) begin
          run_nxt_s = 6'd0;
          if (k_r == 6'd63) begin
            state_nxt_s = S_FIN;
          end else begin
            k_nxt_s     = k_r + 6'd1;
            state_nxt_s = S_RD;
          end
        end else begin
          state_nxt_s = S_EMIT;
        end
      end
      S_EOB: begin
        if (hs_s) begin
          state_nxt_s = S_FIN;
        end else begin
          state_nxt_s = S_EOB;
        end
      end
      S_FIN:   state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Output values derived from the upcoming state so the ports can be registered.
  always_comb begin
    busy_nxt_s = (state_nxt_s != S_IDLE) && (state_nxt_s != S_FIN);
    done_nxt_s = (state_nxt_s == S_FIN);
    if (state_nxt_s == S_RD) begin
      addr_nxt_s = ADDR_W'(zz_map(k_nxt_s) >> 1);
    end else begin
      addr_nxt_s = mem_addr_o;
    end
    valid_nxt_s   = 1'b0;
    dc_nxt_s      = 1'b0;
    run_out_nxt_s = 4'd0;
    size_nxt_s    = 4'd0;
    amp_nxt_s     = 11'd0;
    case (state_nxt_s)
      S_EMIT: begin
        valid_nxt_s   = 1'b1;
        dc_nxt_s      = pend_dc_nxt_s;
        run_out_nxt_s = pend_run_nxt_s;
        size_nxt_s    = pend_size_nxt_s;
        amp_nxt_s     = pend_amp_nxt_s;
      end
      S_ZRL: begin
        valid_nxt_s   = 1'b1;
        run_out_nxt_s = 4'd15;
      end
      S_EOB:   valid_nxt_s = 1'b1;
      default: valid_nxt_s = 1'b0;
    endcase
  end

  // Registered output ports.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      mem_addr_o  <= '0;
      sym_valid_o <= 1'b0;
      sym_dc_o    <= 1'b0;
      sym_run_o   <= 4'd0;
      sym_size_o  <= 4'd0;
      sym_amp_o   <= 11'd0;
    end else begin
      busy_o      <= busy_nxt_s;
      done_o      <= done_nxt_s;
      mem_addr_o  <= addr_nxt_s;
      sym_valid_o <= valid_nxt_s;
      sym_dc_o    <= dc_nxt_s;
      sym_run_o   <= run_out_nxt_s;
      sym_size_o  <= size_nxt_s;
      sym_amp_o   <= amp_nxt_s;
    end
  end

endmodule

// File: tb/tb_jpeg_rle.sv
// Directed bench for jpeg_rle: block memory model, symbol monitor and
// hand-computed expected symbol streams.
module tb_jpeg_rle;

  logic        clk = 1'b0;
  logic        rst_i, start_i, clr_dc_i, sym_ready_i;
  logic        busy_o, done_o, sym_valid_o, sym_dc_o;
  logic [4:0]  mem_addr_o;
  logic [31:0] mem_dat_i;
  logic [3:0]  sym_run_o, sym_size_o;
  logic [10:0] sym_amp_o;

  logic signed [15:0] mem [64];
  logic [19:0] sym_q [$];
  logic [19:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int lat;

  jpeg_rle #(.ADDR_W(5), .COEF_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .clr_dc_i(clr_dc_i),
    .busy_o(busy_o), .done_o(done_o), .mem_addr_o(mem_addr_o), .mem_dat_i(mem_dat_i),
    .sym_valid_o(sym_valid_o), .sym_ready_i(sym_ready_i), .sym_dc_o(sym_dc_o),
    .sym_run_o(sym_run_o), .sym_size_o(sym_size_o), .sym_amp_o(sym_amp_o)
  );

  always #5 clk = ~clk;

  // Output memory: data one cycle after the address.
  always @(posedge clk) mem_dat_i <= {mem[{mem_addr_o, 1'b0}], mem[{mem_addr_o, 1'b1}]};

  // Symbol and done monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (sym_valid_o && sym_ready_i) sym_q.push_back({sym_dc_o, sym_run_o, sym_size_o, sym_amp_o});
    if (done_o) done_cnt++;
  end

  function automatic logic [19:0] mk(input logic dc, input logic [3:0] run,
                                     input logic [3:0] size, input logic [10:0] amp);
    return {dc, run, size, amp};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 16'sd0;
  endtask

  task automatic start_block(input logic clr);
    @(posedge clk); #1;
    start_i = 1'b1; clr_dc_i = clr;
    @(posedge clk); #1;
    start_i = 1'b0; clr_dc_i = 1'b0;
    sym_q.delete();
    done_cnt = 0;
  endtask

  task automatic finish_block(input string tag, output int cyc);
    cyc = 0;
    while (done_o !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({tag, "_busy"}, busy_o, 1'b1);
    end
    check({tag, "_done"}, done_o, 1'b1);
    @(negedge clk);
    check({tag, "_idle"}, {done_o, busy_o}, 2'b00);
    check({tag, "_nsym"}, sym_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sym_q.size(); i++)
      check($sformatf("%s_sym%0d", tag, i), sym_q[i], exp_q[i]);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; clr_dc_i = 1'b0; sym_ready_i = 1'b1;
    clear_mem();
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("reset", {busy_o, done_o, sym_valid_o, sym_dc_o, sym_run_o, sym_size_o, sym_amp_o, mem_addr_o}, 32'd0);

    // DC=5, all AC zero
    clear_mem(); mem[0] = 16'sd5;
    exp_q = '{mk(1'b1, 4'd0, 4'd3, 11'h5), mk(1'b0, 4'd0, 4'd0, 11'h0)};
    start_block(1'b0); finish_block("dc5", lat);
    check("dc5_latency", lat, 32'd131);

    // Same block: difference is zero
    exp_q = '{mk(1'b1, 4'd0, 4'd0, 11'h0), mk(1'b0, 4'd0, 4'd0, 11'h0)};
    start_block(1'b0); finish_block("dc5b", lat);

    // Cleared predictor, DC=-3
    mem[0] = -16'sd3;
    exp_q = '{mk(1'b1, 4'd0, 4'd2, 11'h0), mk(1'b0, 4'd0, 4'd0, 11'h0)};
    start_block(1'b1); finish_block("dcm3", lat);

    // k=1 (natural 1) = -1
    clear_mem(); mem[1] = -16'sd1;
    exp_q = '{mk(1'b1, 4'd0, 4'd0, 11'h0), mk(1'b0, 4'd0, 4'd1, 11'h0), mk(1'b0, 4'd0, 4'd0, 11'h0)};
    start_block(1'b1); finish_block("k1", lat);

    // k=20 (natural 40) = 1: one ZRL then run 3
    clear_mem(); mem[40] = 16'sd1;
    exp_q = '{mk(1'b1, 4'd0, 4'd0, 11'h0), mk(1'b0, 4'd15, 4'd0, 11'h0),
              mk(1'b0, 4'd3, 4'd1, 11'h1), mk(1'b0, 4'd0, 4'd0, 11'h0)};
    start_block(1'b0); finish_block("k20", lat);

    // k=63 = 1023: three ZRLs, run 14, no EOB
    clear_mem(); mem[63] = 16'sd1023;
    exp_q = '{mk(1'b1, 4'd0, 4'd0, 11'h0), mk(1'b0, 4'd15, 4'd0, 11'h0), mk(1'b0, 4'd15, 4'd0, 11'h0),
              mk(1'b0, 4'd15, 4'd0, 11'h0), mk(1'b0, 4'd14, 4'd10, 11'h3FF)};
    start_block(1'b0); finish_block("k63", lat);

    // Saturation: DC -5000 -> -1023, AC 3000 -> 1023
    clear_mem(); mem[0] = -16'sd5000; mem[1] = 16'sd3000;
    exp_q = '{mk(1'b1, 4'd0, 4'd10, 11'h0), mk(1'b0, 4'd0, 4'd10, 11'h3FF), mk(1'b0, 4'd0, 4'd0, 11'h0)};
    start_block(1'b0); finish_block("sat", lat);

    // Largest DC swing: 1023 - (-1023) = 2046, size 11
    clear_mem(); mem[0] = 16'sd3000;
    exp_q = '{mk(1'b1, 4'd0, 4'd11, 11'h7FE), mk(1'b0, 4'd0, 4'd0, 11'h0)};
    start_block(1'b0); finish_block("dcmax", lat);

    // Back-pressure on an AC symbol (k=5, natural 2, word 1)
    clear_mem(); mem[2] = 16'sd7;
    exp_q = '{mk(1'b1, 4'd0, 4'd0, 11'h0), mk(1'b0, 4'd4, 4'd3, 11'h7), mk(1'b0, 4'd0, 4'd0, 11'h0)};
    sym_ready_i = 1'b0;
    start_block(1'b1);
    for (int i = 0; i < 50 && !sym_valid_o; i++) @(negedge clk);
    check("stall_dcsym", {sym_valid_o, sym_dc_o, sym_run_o, sym_size_o, sym_amp_o}, {1'b1, mk(1'b1, 4'd0, 4'd0, 11'h0)});
    @(posedge clk); #1 sym_ready_i = 1'b1;
    @(posedge clk); #1 sym_ready_i = 1'b0;
    for (int i = 0; i < 50 && !sym_valid_o; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("stall_hold%0d", i),
            {sym_valid_o, sym_dc_o, sym_run_o, sym_size_o, sym_amp_o, mem_addr_o},
            {1'b1, mk(1'b0, 4'd4, 4'd3, 11'h7), 5'd1});
    end
    @(posedge clk); #1 sym_ready_i = 1'b1;
    finish_block("stall", lat);

    // Reset mid-scan with DC=9, then DC=4 must use a zero predictor
    clear_mem(); mem[0] = 16'sd9;
    start_block(1'b0);
    repeat (60) @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk); #1;
    check("rst_mid", {busy_o, sym_valid_o, done_o}, 3'b000);
    rst_i = 1'b0;
    sym_q.delete(); done_cnt = 0;
    repeat (30) @(negedge clk);
    check("rst_quiet", {done_cnt[15:0], 16'(sym_q.size())}, 32'd0);
    mem[0] = 16'sd4;
    exp_q = '{mk(1'b1, 4'd0, 4'd3, 11'h4), mk(1'b0, 4'd0, 4'd0, 11'h0)};
    start_block(1'b0); finish_block("postrst", lat);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
